// File: rtl/float_normalize.sv
// float_normalize
//   Post-add normalisation for single-precision addition. It takes the raw
//   sign, exponent and 25-bit magnitude from the adder and produces a packed
//   IEEE-754 single. A carry-out is resolved with one right shift.
//   Cancellation is resolved with one left shift per cycle. Rounding
//   truncates, denormals flush to zero, and only one operation is in flight.
// Ports
//   clk, reset_n              clock, async active-low reset
//   in_valid/in_ready         upstream handshake (in_ready == state IDLE)
//   in_sign/in_exp/in_mant    raw operand; mant[24]=carry, mant[23]=hidden
//   out_valid/out_ready       downstream handshake, out_valid registered
//   out                       {sign, exp[7:0], frac[22:0]}, registered
//   shift_count               left shifts applied to the current/last result
module float_normalize (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [4:0]  shift_count
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;

  logic        sign_r;
  logic [7:0]  exp_r;
  logic [24:0] mant_r;
  logic [4:0]  cnt_r;

  // Shift-step source: the raw operand on accept, the working regs in SHIFT.
  // The first left shift happens on the accept edge, so k shifts finish on
  // the k-th edge counting the accept edge.
  logic        src_sign;
  logic [7:0]  src_exp, dec_exp, inc_exp;
  logic [24:0] src_mant, sh_mant;
  logic [4:0]  src_cnt, inc_cnt;

  logic        fin;      // operation completes on this edge
  logic [31:0] res;      // result loaded into out when fin
  logic [4:0]  res_cnt;  // shift_count loaded when fin

  assign in_ready = (state == IDLE);
  assign inc_exp  = in_exp + 8'd1;

  always_comb begin
    if (state == IDLE) begin
      src_sign = in_sign;
      src_exp  = in_exp;
      src_mant = in_mant;
      src_cnt  = '0;
    end else begin
      src_sign = sign_r;
      src_exp  = exp_r;
      src_mant = mant_r;
      src_cnt  = cnt_r;
    end
    sh_mant = src_mant << 1;
    dec_exp = src_exp - 8'd1;
    inc_cnt = src_cnt + 5'd1;
  end

  always_comb begin
    fin     = 1'b0;
    res     = '0;
    res_cnt = '0;
    if (state == IDLE && in_exp == 8'hFF) begin
      fin = 1'b1;
      res = {in_sign, 8'hFF, 23'h0};
    end else if (state == IDLE && in_mant == '0) begin
      fin = 1'b1;            // exact zero is always +0
    end else if (state == IDLE && in_mant[24]) begin
      fin = 1'b1;
      res = (inc_exp == 8'hFF) ? {in_sign, 8'hFF, 23'h0}
                               : {in_sign, inc_exp, in_mant[23:1]};
    end else if (state == IDLE && in_mant[23]) begin
      fin = 1'b1;
      res = {in_sign, in_exp, in_mant[22:0]};
    end else if (state == IDLE && in_exp <= 8'd1) begin
      fin = 1'b1;            // no room to shift at all
      res = {in_sign, 31'h0};
    end else if (sh_mant[23]) begin
      fin     = 1'b1;
      res     = {src_sign, dec_exp, sh_mant[22:0]};
      res_cnt = inc_cnt;
    end else if (dec_exp == 8'd1) begin
      fin     = 1'b1;        // another shift would reach exponent 0
      res     = {src_sign, 31'h0};
      res_cnt = inc_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sign_r      <= 1'b0;
      exp_r       <= '0;
      mant_r      <= '0;
      cnt_r       <= '0;
      out_valid   <= 1'b0;
      out         <= '0;
      shift_count <= '0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (state == SHIFT || in_valid) begin
            if (fin) begin
              state       <= DONE;
              out         <= res;
              shift_count <= res_cnt;
              out_valid   <= 1'b1;
            end else begin
              state  <= SHIFT;
              sign_r <= src_sign;
              exp_r  <= dec_exp;
              mant_r <= sh_mant;
              cnt_r  <= inc_cnt;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_normalize.sv
module tb_float_normalize;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid, out_ready;
  logic [31:0] out;
  logic [4:0]  shift_count;

  int nvec = 0;
  int nmis = 0;

  float_normalize dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .shift_count(shift_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Apply one operand, wait for the result (bounded), check it, handshake.
  // Latency counts posedges from the accept edge inclusive.
  task automatic apply(input string tag, input logic s, input logic [7:0] e,
                       input logic [24:0] m, input logic [31:0] want,
                       input int wcnt, input int wlat);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(wlat));
    chk({tag, "_out"}, out, want);
    chk({tag, "_cnt"}, 32'(shift_count), 32'(wcnt));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0;
    #2;
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'h0);
    chk("rst_cnt", 32'(shift_count), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk); reset_n = 1'b1;

    apply("norm",   1'b0, 8'h80, 25'h0800000, 32'h40000000, 0, 1);
    apply("carry",  1'b0, 8'h7F, 25'h1800000, 32'h40400000, 0, 1);
    apply("ovf",    1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 0, 1);
    apply("trunc",  1'b0, 8'h80, 25'h1FFFFFF, 32'h40FFFFFF, 0, 1);
    apply("cancel", 1'b0, 8'h80, 25'h0000001, 32'h34800000, 23, 23);
    apply("zero",   1'b1, 8'h80, 25'h0000000, 32'h00000000, 0, 1);
    apply("uflow",  1'b1, 8'h03, 25'h0000100, 32'h80000000, 2, 2);
    apply("inf",    1'b1, 8'hFF, 25'h0400000, 32'hFF800000, 0, 1);
    apply("iflush", 1'b0, 8'h01, 25'h0000100, 32'h00000000, 0, 1);
    apply("sh2",    1'b1, 8'h85, 25'h0200000, 32'hC1800000, 2, 2);
    apply("emin",   1'b0, 8'h02, 25'h0400000, 32'h00800000, 1, 1);

    // Backpressure: result held, a pending operand is not taken until after
    // the handshake.
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_exp = 8'h7F; in_mant = 25'h1800000;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_out", out, 32'h40000000);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_vld", 32'(out_valid), 32'd0);
    chk("bp_hs_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_vld", 32'(out_valid), 32'd1);
    chk("bp_next_out", out, 32'h40400000);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset five cycles into the 23-shift case (out holds 3.0 beforehand).
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'h80; in_mant = 25'h0000001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_vld", 32'(out_valid), 32'd0);
    chk("mr_out", out, 32'h0);
    chk("mr_cnt", 32'(shift_count), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("mr_rdy", 32'(in_ready), 32'd1);
    apply("post", 1'b1, 8'h85, 25'h0200000, 32'hC1800000, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
